uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched_if.sv | 29 ++
 rtl/uart_tx_sched.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Client / uart_tx bundle for the round-robin UART frame scheduler.
//
// Handshake: the scheduler raises strt_tx for exactly one cycle with tx_data
// already valid; tx_data then holds until the next byte is loaded. uart_tx
// drops tx_done the cycle after strt_tx and raises it again when the byte has
// left the wire. A client offers data[8i+7:8i] continuously and advances to its
// next byte after each byte_rd[i] pulse. grant is one-hot for a whole frame and
// frm_done pulses once when the frame's last byte has completed.
interface uart_tx_sched_if;
  logic [3:0]  req;
  logic [15:0] len;
  logic [31:0] data;
  logic [3:0]  byte_rd;
  logic [3:0]  grant;
  logic [3:0]  frm_done;
  logic        strt_tx;
  logic [7:0]  tx_data;
  logic        tx_done;

  modport master (
    input  req, len, data, tx_done,
    output byte_rd, grant, frm_done, strt_tx, tx_data
  );

  modport slave (
    output req, len, data, tx_done,
    input  byte_rd, grant, frm_done, strt_tx, tx_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among four byte-stream clients.
// Each granted burst goes out as header, LEN payload bytes, optional XOR checksum.
module uart_tx_sched #(
  parameter bit          CHK_EN = 1'b1,
  parameter int unsigned GAP    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_sched_if.master  bus,
  output logic [2:0]       o_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WCLR  = 3'd2;
  localparam logic [2:0] S_WDONE = 3'd3;
  localparam logic [2:0] S_GAPW  = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_END   = 3'd6;

  localparam logic [1:0] P_HDR  = 2'd0;
  localparam logic [1:0] P_DATA = 2'd1;
  localparam logic [1:0] P_CSUM = 2'd2;

  logic [2:0] r_state;
  logic [1:0] r_phase;
  logic [1:0] r_id;
  logic [1:0] r_ptr;
  logic [3:0] r_len;
  logic [3:0] r_rem;
  logic [7:0] r_csum;
  logic [7:0] r_gap_cnt;
  logic       r_strt_tx;
  logic [7:0] r_tx_data;
  logic [3:0] r_grant;
  logic [3:0] r_byte_rd;
  logic [3:0] r_frm_done;

  logic       w_any_req;
  logic [1:0] w_winner;
  logic [3:0] w_len_sel;
  logic [7:0] w_hdr;
  logic [7:0] w_cur_data;
  logic [7:0] w_load_byte;
  logic [3:0] w_rem_dec;

  // First requesting client at or after the pointer; the scan runs backwards so
  // the smallest offset is the one left standing.
  always_comb begin
    w_any_req = 1'b0;
    w_winner  = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[r_ptr + 2'(k)]) begin
        w_any_req = 1'b1;
        w_winner  = r_ptr + 2'(k);
      end
    end
  end

  assign w_len_sel  = bus.len[{w_winner, 2'b00} +: 4];
  assign w_hdr      = {2'b10, r_id, r_len};
  assign w_cur_data = bus.data[{r_id, 3'b000} +: 8];
  assign w_rem_dec  = r_rem - 4'd1;

  // Byte source for the next load, selected by frame phase.
  always_comb begin
    w_load_byte = w_hdr;
    case (r_phase)
      P_DATA:  w_load_byte = w_cur_data;
      P_CSUM:  w_load_byte = r_csum;
      default: w_load_byte = w_hdr;
    endcase
  end

  // Frame sequencer: arbitration, byte loads, tx_done wait, gap and frame end.
  // tx_done is ignored in WCLR because it still reflects the previous byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_phase    <= P_HDR;
      r_id       <= 2'd0;
      r_ptr      <= 2'd0;
      r_len      <= 4'd0;
      r_rem      <= 4'd0;
      r_csum     <= 8'h00;
      r_gap_cnt  <= 8'd0;
      r_strt_tx  <= 1'b0;
      r_tx_data  <= 8'h00;
      r_grant    <= 4'd0;
      r_byte_rd  <= 4'd0;
      r_frm_done <= 4'd0;
    end else begin
      r_strt_tx  <= 1'b0;
      r_byte_rd  <= 4'd0;
      r_frm_done <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_id    <= w_winner;
            r_grant <= 4'b0001 << w_winner;
            r_len   <= w_len_sel;
            r_phase <= P_HDR;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_tx_data <= w_load_byte;
          r_strt_tx <= 1'b1;
          if (r_phase == P_HDR) begin
            r_csum <= w_hdr;
          end else if (r_phase == P_DATA) begin
            r_csum    <= r_csum ^ w_cur_data;
            r_byte_rd <= 4'b0001 << r_id;
          end
          r_state <= S_WCLR;
        end
        S_WCLR: r_state <= S_WDONE;
        S_WDONE: begin
          if (bus.tx_done) begin
            if (GAP == 0) begin
              r_state <= S_NEXT;
            end else begin
              r_gap_cnt <= 8'(GAP - 1);
              r_state   <= S_GAPW;
            end
          end
        end
        S_GAPW: begin
          if (r_gap_cnt == 8'd0) r_state <= S_NEXT;
          else                   r_gap_cnt <= r_gap_cnt - 8'd1;
        end
        S_NEXT: begin
          case (r_phase)
            P_HDR: begin
              if (r_len != 4'd0) begin
                r_phase <= P_DATA;
                r_rem   <= r_len;
                r_state <= S_LOAD;
              end else if (CHK_EN) begin
                r_phase <= P_CSUM;
                r_state <= S_LOAD;
              end else begin
                r_state <= S_END;
              end
            end
            P_DATA: begin
              r_rem <= w_rem_dec;
              if (w_rem_dec != 4'd0) begin
                r_state <= S_LOAD;
              end else if (CHK_EN) begin
                r_phase <= P_CSUM;
                r_state <= S_LOAD;
              end else begin
                r_state <= S_END;
              end
            end
            default: r_state <= S_END;
          endcase
        end
        S_END: begin
          r_frm_done <= 4'b0001 << r_id;
          r_grant    <= 4'd0;
          r_ptr      <= r_id + 2'd1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.strt_tx  = r_strt_tx;
  assign bus.tx_data  = r_tx_data;
  assign bus.grant    = r_grant;
  assign bus.byte_rd  = r_byte_rd;
  assign bus.frm_done = r_frm_done;
  assign o_state      = r_state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: one instance with checksum and no gap, one without
// checksum and GAP=10, each with a small uart_tx model and client buffers.
module tb_uart_tx_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  uart_tx_sched_if ifa();
  uart_tx_sched_if ifb();
  logic [2:0] st_a, st_b;

  uart_tx_sched #(.CHK_EN(1'b1), .GAP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .o_state(st_a));
  uart_tx_sched #(.CHK_EN(1'b0), .GAP(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .o_state(st_b));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- client payload buffers ----------------
  logic [7:0] buf_a [4][64];
  logic [7:0] buf_b [4][64];
  logic [5:0] rd_a [4] = '{default: '0};
  logic [5:0] rd_b [4] = '{default: '0};
  logic [5:0] wp_a [4] = '{default: '0};
  logic [5:0] wp_b [4] = '{default: '0};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ifa.byte_rd[i]) rd_a[i] <= rd_a[i] + 6'd1;
      if (ifb.byte_rd[i]) rd_b[i] <= rd_b[i] + 6'd1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_data
    assign ifa.data[8*g +: 8] = buf_a[g][rd_a[g]];
    assign ifb.data[8*g +: 8] = buf_b[g][rd_b[g]];
  end

  // ---------------- uart_tx models (7 cycles per byte) ----------------
  logic u_done_a = 1'b0, u_done_b = 1'b0;
  int   u_busy_a = 0,    u_busy_b = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      u_done_a <= 1'b0; u_busy_a <= 0;
      u_done_b <= 1'b0; u_busy_b <= 0;
    end else begin
      if (ifa.strt_tx) begin
        u_done_a <= 1'b0; u_busy_a <= 6;
      end else if (u_busy_a > 0) begin
        u_busy_a <= u_busy_a - 1;
        if (u_busy_a == 1) u_done_a <= 1'b1;
      end
      if (ifb.strt_tx) begin
        u_done_b <= 1'b0; u_busy_b <= 6;
      end else if (u_busy_b > 0) begin
        u_busy_b <= u_busy_b - 1;
        if (u_busy_b == 1) u_done_b <= 1'b1;
      end
    end
  end

  assign ifa.tx_done = u_done_a;
  assign ifb.tx_done = u_done_b;

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q_a[$];   // {grant, tx_data}
  logic [11:0] exp_q_b[$];
  logic [3:0]  done_q_a[$];
  logic [3:0]  done_q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  logic prev_done_a = 1'b0, prev_done_b = 1'b0;
  int   rise_a = 0, rise_b = 0;
  bit   in_frm_a = 1'b0, in_frm_b = 1'b0;
  int   frames_a = 0, frames_b = 0;
  bit   bad_grant_a = 1'b0, bad_grant_b = 1'b0;

  // Monitor A: every strt_tx must find uart_tx idle, match the next expected
  // {grant,byte}, and inside a frame follow tx_done rise by exactly 3 cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frm_a = 1'b0; prev_done_a = 1'b0;
    end else begin
      if (ifa.tx_done && !prev_done_a) rise_a = cyc;
      prev_done_a = ifa.tx_done;
      if (!$onehot0(ifa.grant)) bad_grant_a = 1'b1;
      if (ifa.strt_tx) begin
        check("a_uart_idle_at_strt", u_busy_a, 0);
        if (in_frm_a) check("a_done_to_strt_cycles", cyc - rise_a, 3);
        in_frm_a = 1'b1;
        if (exp_q_a.size() == 0) begin
          n_chk++;
          $display("FAIL a_unexpected_byte: got %h expected none", {ifa.grant, ifa.tx_data});
        end else check("a_grant_and_byte", {ifa.grant, ifa.tx_data}, exp_q_a.pop_front());
      end
      if (ifa.frm_done != 4'd0) begin
        frames_a++; in_frm_a = 1'b0;
        if (done_q_a.size() == 0) begin
          n_chk++;
          $display("FAIL a_unexpected_frm_done: got %h expected none", ifa.frm_done);
        end else check("a_frm_done", {ifa.grant, ifa.frm_done}, {4'd0, done_q_a.pop_front()});
      end
    end
  end

  // Monitor B: same checks with GAP=10, so tx_done rise to strt_tx is 13 cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frm_b = 1'b0; prev_done_b = 1'b0;
    end else begin
      if (ifb.tx_done && !prev_done_b) rise_b = cyc;
      prev_done_b = ifb.tx_done;
      if (!$onehot0(ifb.grant)) bad_grant_b = 1'b1;
      if (ifb.strt_tx) begin
        check("b_uart_idle_at_strt", u_busy_b, 0);
        if (in_frm_b) check("b_done_to_strt_cycles", cyc - rise_b, 13);
        in_frm_b = 1'b1;
        if (exp_q_b.size() == 0) begin
          n_chk++;
          $display("FAIL b_unexpected_byte: got %h expected none", {ifb.grant, ifb.tx_data});
        end else check("b_grant_and_byte", {ifb.grant, ifb.tx_data}, exp_q_b.pop_front());
      end
      if (ifb.frm_done != 4'd0) begin
        frames_b++; in_frm_b = 1'b0;
        if (done_q_b.size() == 0) begin
          n_chk++;
          $display("FAIL b_unexpected_frm_done: got %h expected none", ifb.frm_done);
        end else check("b_frm_done", {ifb.grant, ifb.frm_done}, {4'd0, done_q_b.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Load a client's payload and queue the frame as the UART must see it.
  task automatic frame_a(input logic [7:0] hdr, input int id, input int n,
                         input logic [119:0] pay, input logic [7:0] csum);
    logic [3:0] g;
    g = 4'b0001 << id;
    ifa.len[4*id +: 4] = 4'(n);
    exp_q_a.push_back({g, hdr});
    for (int k = 0; k < n; k++) begin
      buf_a[id][wp_a[id]] = pay[8*k +: 8];
      wp_a[id] = wp_a[id] + 6'd1;
      exp_q_a.push_back({g, pay[8*k +: 8]});
    end
    exp_q_a.push_back({g, csum});
    done_q_a.push_back(g);
  endtask

  task automatic frame_b(input logic [7:0] hdr, input int id, input int n,
                         input logic [119:0] pay);
    logic [3:0] g;
    g = 4'b0001 << id;
    ifb.len[4*id +: 4] = 4'(n);
    exp_q_b.push_back({g, hdr});
    for (int k = 0; k < n; k++) begin
      buf_b[id][wp_b[id]] = pay[8*k +: 8];
      wp_b[id] = wp_b[id] + 6'd1;
      exp_q_b.push_back({g, pay[8*k +: 8]});
    end
    done_q_b.push_back(g);
  endtask

  task automatic pulse_req_a(input logic [3:0] r);
    ifa.req = r; @(posedge clk); #2; ifa.req = 4'd0;
  endtask

  task automatic pulse_req_b(input logic [3:0] r);
    ifb.req = r; @(posedge clk); #2; ifb.req = 4'd0;
  endtask

  task automatic wait_frames_a(input int target, input string name);
    int k = 0;
    while (frames_a < target && k < 600) begin @(posedge clk); #2; k++; end
    check(name, frames_a, target);
  endtask

  task automatic wait_frames_b(input int target, input string name);
    int k = 0;
    while (frames_b < target && k < 600) begin @(posedge clk); #2; k++; end
    check(name, frames_b, target);
  endtask

  task automatic wait_rd_a(input int id, input logic [5:0] target);
    int k = 0;
    while (rd_a[id] != target && k < 300) begin @(posedge clk); #2; k++; end
    check("a_wait_byte_rd", rd_a[id], target);
  endtask

  // ---------------- directed sequence ----------------
  logic [5:0] r0;
  int f0;

  initial begin
    ifa.req = 4'd0; ifa.len = 16'd0;
    ifb.req = 4'd0; ifb.len = 16'd0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 64; j++) begin
        buf_a[i][j] = 8'h00; buf_b[i][j] = 8'h00;
      end

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("a_reset_outputs", {st_a, ifa.strt_tx, ifa.tx_data, ifa.grant, ifa.byte_rd, ifa.frm_done}, 0);
    check("b_reset_outputs", {st_b, ifb.strt_tx, ifb.tx_data, ifb.grant, ifb.byte_rd, ifb.frm_done}, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #2;

    // Client 0, len 3, A5 3C FF: 83 A5 3C FF E5
    r0 = rd_a[0];
    frame_a(8'h83, 0, 3, 120'hFF3CA5, 8'hE5);
    pulse_req_a(4'b0001);
    wait_frames_a(1, "a_single_frame_done");
    check("a_byte_rd_count_c0", 6'(rd_a[0] - r0), 3);

    // No-checksum instance: client 2 len 0 sends only A0
    r0 = rd_b[2];
    frame_b(8'hA0, 2, 0, 120'h0);
    pulse_req_b(4'b0100);
    wait_frames_b(1, "b_len0_frame_done");
    check("b_byte_rd_count_c2", 6'(rd_b[2] - r0), 0);

    // GAP=10: client 1 len 2 sends 92 5A 6B
    r0 = rd_b[1];
    frame_b(8'h92, 1, 2, 120'h6B5A);
    pulse_req_b(4'b0010);
    wait_frames_b(2, "b_gap_frame_done");
    check("b_byte_rd_count_c1", 6'(rd_b[1] - r0), 2);

    // Pointer back to 0, then all four requesting with len 1: order 0,1,2,3,0
    rst_n = 1'b0; @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #2;
    frame_a(8'h81, 0, 1, 120'h10, 8'h91);
    frame_a(8'h91, 1, 1, 120'h20, 8'hB1);
    frame_a(8'hA1, 2, 1, 120'h30, 8'h91);
    frame_a(8'hB1, 3, 1, 120'h40, 8'hF1);
    frame_a(8'h81, 0, 1, 120'h11, 8'h90);
    f0 = frames_a;
    ifa.req = 4'b1111;
    wait_frames_a(f0 + 4, "a_rr_four_frames");
    ifa.req = 4'd0;
    wait_frames_a(f0 + 5, "a_rr_fifth_frame");
    check("a_grant_onehot", bad_grant_a, 0);

    // Reset during client 1's second data byte abandons the frame
    r0 = rd_a[1];
    frame_a(8'h94, 1, 4, 120'hD4D3D2D1, 8'h00);
    f0 = frames_a;
    pulse_req_a(4'b0010);
    wait_rd_a(1, r0 + 6'd2);
    rst_n = 1'b0;
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);
    check("a_after_abort_outputs", {ifa.grant, ifa.strt_tx, ifa.frm_done, ifa.byte_rd}, 0);
    check("a_abort_unsent_bytes", exp_q_a.size(), 3);
    check("a_abort_pending_done", done_q_a.size(), 1);
    exp_q_a.delete();
    done_q_a.delete();
    wp_a[1] = rd_a[1];
    repeat (20) @(negedge clk);
    check("a_abort_no_frm_done", frames_a, f0);
    check("a_abort_byte_rd_stop", 6'(rd_a[1] - r0), 2);

    // After reset, req 0011: client 0 first (80 80), then client 1 (90 90)
    @(posedge clk); #2;
    frame_a(8'h80, 0, 0, 120'h0, 8'h80);
    frame_a(8'h90, 1, 0, 120'h0, 8'h90);
    ifa.req = 4'b0011;
    wait_frames_a(f0 + 1, "a_post_reset_first");
    ifa.req = 4'd0;
    wait_frames_a(f0 + 2, "a_post_reset_second");

    repeat (5) @(posedge clk);
    check("a_queue_drained", exp_q_a.size() + done_q_a.size(), 0);
    check("b_queue_drained", exp_q_b.size() + done_q_b.size(), 0);
    check("b_grant_onehot", bad_grant_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
